bsg_credit_return_accum: RTL and testbench



---
 rtl/bsg_credit_return_accum_pkg.sv | 8 +
 rtl/bsg_counter_sat_up.sv | 37 +++
 rtl/bsg_credit_return_accum.sv | 80 ++++++++
 tb/tb_bsg_credit_return_accum.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_credit_return_accum_pkg.sv
// Shared defaults for the receiver-side credit return accumulator.
// Widths match the sender's credit counter.
package bsg_credit_return_accum_pkg;

  localparam int unsigned credit_width_gp  = 16;
  localparam int unsigned credit_thresh_gp = 4;

endpackage

// File: rtl/bsg_counter_sat_up.sv
// Saturating up-counter with synchronous clear.
// incr_o is the saturated next value; sat_o flags a lost increment.
module bsg_counter_sat_up #(
  parameter int unsigned width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o,
  output logic [width_p-1:0] incr_o,
  output logic               sat_o
);

  logic [width_p-1:0] cnt_q, cnt_d;
  logic               max;

  assign max = &cnt_q;

  always_comb begin
    incr_o = cnt_q;
    if (up_i && !max)
      incr_o = cnt_q + 1'b1;
  end

  assign cnt_d   = clear_i ? '0 : incr_o;
  assign sat_o   = up_i & max;
  assign count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bsg_credit_return_accum.sv
// Counts freed credits and returns them to the sender in batches.
// out_v_q doubles as the IDLE/SEND state bit.
module bsg_credit_return_accum
  import bsg_credit_return_accum_pkg::*;
#(
  parameter int unsigned width_p     = credit_width_gp,
  parameter int unsigned threshold_p = credit_thresh_gp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               consume_i,
  input  logic               flush_i,
  output logic               credit_v_o,
  output logic [width_p-1:0] credit_cnt_o,
  input  logic               credit_ready_i,
  output logic               overflow_o
);

  localparam logic [width_p-1:0] thresh_lp = width_p'(threshold_p);

  logic [width_p-1:0] acc_q, sum;
  logic [width_p-1:0] out_cnt_q, out_cnt_d;
  logic               out_v_q, out_v_d;
  logic               flush_pend_q, flush_pend_d;
  logic               overflow_q, overflow_d;
  logic               sat, launch, hs, flush_any;

  bsg_counter_sat_up #(
    .width_p (width_p)
  ) acc (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (launch),
    .up_i    (consume_i),
    .count_o (acc_q),
    .incr_o  (sum),
    .sat_o   (sat)
  );

  assign flush_any = flush_i | flush_pend_q;
  assign hs        = out_v_q & credit_ready_i;
  assign launch    = ~out_v_q
                   & ((sum >= thresh_lp)
                   | (flush_any & (sum != '0)));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_v_q      <= 1'b0;
      out_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      out_v_q      <= out_v_d;
      out_cnt_q    <= out_cnt_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    out_v_d      = out_v_q;
    out_cnt_d    = out_cnt_q;
    flush_pend_d = flush_any;
    overflow_d   = overflow_q | sat;
    unique case (1'b1)
      launch: begin
        out_v_d      = 1'b1;
        out_cnt_d    = sum;
        flush_pend_d = 1'b0;
      end
      hs: out_v_d = 1'b0;
      default: ;
    endcase
  end

  assign credit_v_o   = out_v_q;
  assign credit_cnt_o = out_cnt_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_bsg_credit_return_accum.sv
// Directed and random checks of the credit return accumulator
// against a cycle-level behavioural model.
module tb_bsg_credit_return_accum;

  typedef struct packed {
    int   acc;
    logic v;
    int   cnt;
    logic pend;
    logic ovf;
  } mstate_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1, cons_a = 1'b0, fl_a = 1'b0, rdy_a = 1'b0;
  logic rst_b = 1'b1, cons_b = 1'b0, rdy_b = 1'b0;
  logic        v_a, ovf_a, v_b, ovf_b;
  logic [15:0] cnt_a;
  logic [2:0]  cnt_b;

  int vecs = 0;
  int errs = 0;
  int tot_c = 0;
  int tot_r = 0;
  bit chk_en = 1'b0;
  mstate_t ma = '0;
  mstate_t mb = '0;

  bsg_credit_return_accum #(.width_p(16), .threshold_p(4)) dut_a (
    .clk_i          (clk),
    .reset_i        (rst_a),
    .consume_i      (cons_a),
    .flush_i        (fl_a),
    .credit_v_o     (v_a),
    .credit_cnt_o   (cnt_a),
    .credit_ready_i (rdy_a),
    .overflow_o     (ovf_a)
  );

  bsg_credit_return_accum #(.width_p(3), .threshold_p(7)) dut_b (
    .clk_i          (clk),
    .reset_i        (rst_b),
    .consume_i      (cons_b),
    .flush_i        (1'b0),
    .credit_v_o     (v_b),
    .credit_cnt_o   (cnt_b),
    .credit_ready_i (rdy_b),
    .overflow_o     (ovf_b)
  );

  function automatic mstate_t step(mstate_t s, logic rst, logic c,
                                   logic f, logic r, int th, int mx);
    mstate_t n;
    int      sum;
    n   = s;
    sum = s.acc + (c ? 1 : 0);
    if (sum > mx) sum = mx;
    if (rst) begin
      n = '0;
    end else begin
      if (s.acc == mx && c) n.ovf = 1'b1;
      if (!s.v && (sum >= th || ((f || s.pend) && sum != 0))) begin
        n.v    = 1'b1;
        n.cnt  = sum;
        n.acc  = 0;
        n.pend = 1'b0;
      end else begin
        n.acc  = sum;
        n.pend = s.pend | f;
        if (s.v && r) n.v = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    ma <= step(ma, rst_a, cons_a, fl_a, rdy_a, 4, 65535);
    mb <= step(mb, rst_b, cons_b, 1'b0, rdy_b, 7, 7);
  end

  always @(posedge clk) begin
    if (rst_a) begin
      tot_c <= 0;
      tot_r <= 0;
    end else begin
      if (cons_a) tot_c <= tot_c + 1;
      if (v_a && rdy_a) tot_r <= tot_r + int'(cnt_a);
    end
  end

  task automatic cmp(string nm, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a_valid", int'(v_a), int'(ma.v));
      cmp("a_cnt", int'(cnt_a), ma.cnt);
      cmp("a_ovf", int'(ovf_a), int'(ma.ovf));
      cmp("a_acc", int'(dut_a.acc_q), ma.acc);
      cmp("b_valid", int'(v_b), int'(mb.v));
      cmp("b_cnt", int'(cnt_b), mb.cnt);
      cmp("b_ovf", int'(ovf_b), int'(mb.ovf));
      cmp("b_acc", int'(dut_b.acc_q), mb.acc);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lit_a(string nm, int v, int c, int acc);
    cmp({nm, "_v"}, int'(v_a), v);
    if (v != 0) cmp({nm, "_cnt"}, int'(cnt_a), c);
    cmp({nm, "_acc"}, int'(dut_a.acc_q), acc);
  endtask

  initial begin
    repeat (2) cyc();
    rst_a = 1'b0;
    rst_b = 1'b0;
    chk_en = 1'b1;
    lit_a("reset", 0, 0, 0);
    cmp("reset_ovf", int'(ovf_a), 0);
    cmp("reset_cnt", int'(cnt_a), 0);

    // threshold
    rdy_a = 1'b1;
    cons_a = 1'b1;
    repeat (3) cyc();
    lit_a("thr3", 0, 0, 3);
    cyc();
    lit_a("thr4", 1, 4, 0);
    cons_a = 1'b0;
    cyc();
    lit_a("thr_done", 0, 0, 0);

    // backpressure
    rdy_a = 1'b0;
    cons_a = 1'b1;
    repeat (4) cyc();
    lit_a("bp4", 1, 4, 0);
    repeat (3) cyc();
    lit_a("bp7", 1, 4, 3);
    cons_a = 1'b0;
    rdy_a = 1'b1;
    cyc();
    lit_a("bp_hs", 0, 0, 3);
    cons_a = 1'b1;
    cyc();
    lit_a("bp_second", 1, 4, 0);
    cons_a = 1'b0;
    cyc();

    // flush
    cons_a = 1'b1;
    repeat (2) cyc();
    cons_a = 1'b0;
    fl_a = 1'b1;
    cyc();
    lit_a("flush2", 1, 2, 0);
    fl_a = 1'b0;
    cyc();
    fl_a = 1'b1;
    cyc();
    lit_a("flush_empty", 0, 0, 0);
    fl_a = 1'b0;
    cons_a = 1'b1;
    cyc();
    lit_a("flush_pend1", 1, 1, 0);
    cons_a = 1'b0;
    cyc();

    // consume during handshake
    rdy_a = 1'b0;
    cons_a = 1'b1;
    repeat (4) cyc();
    rdy_a = 1'b1;
    cyc();
    lit_a("sim_hs", 0, 0, 1);
    repeat (2) cyc();
    lit_a("sim_wait", 0, 0, 3);
    cyc();
    lit_a("sim_batch", 1, 4, 0);
    cons_a = 1'b0;
    cyc();

    // random traffic, then drain
    for (int i = 0; i < 1000; i++) begin
      cons_a = 1'($urandom_range(1));
      rdy_a  = 1'($urandom_range(1));
      fl_a   = ($urandom_range(9) == 0);
      cyc();
    end
    cons_a = 1'b0;
    rdy_a = 1'b1;
    fl_a = 1'b1;
    cyc();
    fl_a = 1'b0;
    repeat (6) cyc();
    cmp("drain_acc", int'(dut_a.acc_q), 0);
    cmp("drain_v", int'(v_a), 0);
    cmp("total_returned", tot_r, tot_c);

    // reset while a batch is pending
    rdy_a = 1'b0;
    cons_a = 1'b1;
    repeat (7) cyc();
    lit_a("pre_rst", 1, 4, 3);
    cons_a = 1'b0;
    rst_a = 1'b1;
    cyc();
    lit_a("rst_send", 0, 0, 0);
    cmp("rst_send_ovf", int'(ovf_a), 0);
    rst_a = 1'b0;
    cyc();

    // saturation on the narrow instance
    cons_b = 1'b1;
    repeat (7) cyc();
    cmp("sat_v", int'(v_b), 1);
    cmp("sat_cnt", int'(cnt_b), 7);
    repeat (7) cyc();
    cmp("sat_acc7", int'(dut_b.acc_q), 7);
    cmp("sat_ovf0", int'(ovf_b), 0);
    cyc();
    cmp("sat_acc_hold", int'(dut_b.acc_q), 7);
    cmp("sat_ovf1", int'(ovf_b), 1);
    cons_b = 1'b0;
    repeat (3) cyc();
    cmp("sat_sticky", int'(ovf_b), 1);
    cmp("sat_cnt_hold", int'(cnt_b), 7);
    rst_b = 1'b1;
    cyc();
    cmp("sat_rst_ovf", int'(ovf_b), 0);
    cmp("sat_rst_v", int'(v_b), 0);
    cmp("sat_rst_acc", int'(dut_b.acc_q), 0);
    rst_b = 1'b0;
    repeat (2) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
